// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial: packed-BCD subtractor d = a - b, one decimal digit per clock,
// least-significant digit first. Negative results come back in ten's
// complement with borrow set; any non-BCD operand nibble short-circuits to an
// invalid result without entering RUN.
module bcd_sub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   d,
    output logic                  borrow,
    output logic                  invalid
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_a, r_b, r_d;
    logic [IW-1:0]   r_idx;
    logic            r_br, r_borrow, r_invalid;
    logic            w_bad, w_last;
    logic [4:0]      w_t;
    logic [3:0]      w_di;

    // Flag any operand nibble outside 0..9 on the live inputs
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) w_bad = 1'b1;
        end
    end

    // One digit of subtraction; operands are shifted so the current digit sits in [3:0].
    // t ranges -10..9, so adding 10 modulo 16 to the low nibble gives the corrected digit.
    always_comb begin
        w_t    = {1'b0, r_a[3:0]} - {1'b0, r_b[3:0]} - {4'b0000, r_br};
        w_di   = w_t[4] ? (w_t[3:0] + 4'd10) : w_t[3:0];
        w_last = (r_idx == IW'(DIGITS - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = w_bad ? S_DONE : S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, digit walk and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_d       <= '0;
            r_idx     <= '0;
            r_br      <= 1'b0;
            r_borrow  <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_idx <= '0;
                        r_br  <= 1'b0;
                        if (w_bad) begin
                            r_invalid <= 1'b1;
                            r_d       <= '0;
                            r_borrow  <= 1'b0;
                        end else begin
                            r_invalid <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_a  <= r_a >> 4;
                    r_b  <= r_b >> 4;
                    r_br <= w_t[4];
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == IW'(i)) r_d[4*i +: 4] <= w_di;
                    end
                    if (w_last) r_borrow <= w_t[4];
                    else        r_idx    <= r_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign d       = r_d;
    assign borrow  = r_borrow;
    assign invalid = r_invalid;

endmodule
